// File: rtl/mux_scan_n.sv
// ----------------------------------------------------------------------------
// mux_scan_n
//
// N-channel, W-bit registered multiplexer with two modes:
//   manual    : the S input picks the channel every enabled cycle
//   auto-scan : an internal dwell counter steps round-robin through the
//               channels, holding each one for DWELL enabled cycles
// The output, its channel tag and the framing flags are all registered.
// Data is sampled live every enabled cycle from the selected channel.
//
// Parameters
//   WIDTH    data bits per channel
//   CHANNELS number of input channels (2..16)
//   SEL_W    select width, 2**SEL_W >= CHANNELS
//   DWELL    enabled cycles per channel in scan mode (1..256)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (priority over everything)
//   en     in   global enable; 0 freezes all state, forces wrap low
//   mode   in   0 = manual, 1 = auto-scan
//   S      in   manual channel select
//   I      in   packed inputs, channel k = I[k*WIDTH +: WIDTH]
//   Y      out  registered selected data
//   Y_ch   out  channel index Y came from
//   valid  out  Y / Y_ch hold a legal sample
//   wrap   out  one-cycle pulse on the first channel-0 cycle of each new frame
//   err    out  registered flag: manual select was not a legal channel
//   M      in   (MUX_SCAN_SKIP_MASK_EN only) channel enable mask
//
// Optional feature macro: MUX_SCAN_SKIP_MASK_EN
//   When defined, port M is added. Scan skips channels whose M bit is clear,
//   wrap marks the search passing from index CHANNELS-1 back to a lower one,
//   an all-zero mask drops valid and holds Y, and manual selection of a
//   masked channel is treated as out of range.
// ----------------------------------------------------------------------------
module mux_scan_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          S,
    input  logic [CHANNELS*WIDTH-1:0] I,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          Y_ch,
    output logic                      valid,
    output logic                      wrap,
    output logic                      err
`ifdef MUX_SCAN_SKIP_MASK_EN
    ,
    input  logic [CHANNELS-1:0]       M
`endif
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_SCAN
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [SEL_W-1:0]   r_cursor;     // channel currently being dwelt on
    logic [CNT_W-1:0]   r_cnt;        // enabled cycles spent on r_cursor
    logic               r_wrap_pend;  // last advance wrapped; pulse on next sample
    logic [WIDTH-1:0]   r_y;
    logic [SEL_W-1:0]   r_y_ch;
    logic               r_valid;
    logic               r_wrap;
    logic               r_err;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0]   w_mask;
    logic [2*CHANNELS-1:0] w_mask_dbl;
    logic [2*CHANNELS-1:0] w_rot_cur;   // bit k = mask of channel (cursor+k) mod N
    logic [2*CHANNELS-1:0] w_rot_eff;   // bit k = mask of channel (eff+1+k) mod N
    logic                  w_eff_found;
    logic [SEL_W-1:0]      w_eff_ch;    // channel actually presented this cycle
    logic [SEL_W-1:0]      w_next_ch;   // channel to move to at the dwell boundary
    logic                  w_next_wraps;
    logic                  w_s_legal;
    logic [WIDTH-1:0]      w_scan_data;
    logic [WIDTH-1:0]      w_man_data;
    logic                  w_dwell_done;

`ifdef MUX_SCAN_SKIP_MASK_EN
    assign w_mask = M;
`else
    // Without the mask every channel is eligible, which reduces the search
    // below to a plain round-robin increment.
    assign w_mask = '1;
`endif

    // Doubling the mask turns the circular search into a simple shift.
    assign w_mask_dbl = {w_mask, w_mask};
    assign w_rot_cur  = w_mask_dbl >> r_cursor;
    assign w_rot_eff  = w_mask_dbl >> (int'(w_eff_ch) + 1);

    // First eligible channel at or after the cursor. The loop runs from the
    // far end down so the nearest hit is the one that sticks.
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_eff_found = 1'b0;
        w_eff_ch    = r_cursor;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_rot_cur[k]) begin
                w_eff_found = 1'b1;
                w_eff_ch    = SEL_W'((int'(r_cursor) + k) % CHANNELS);
            end
        end
    end

    // Next eligible channel strictly after the presented one. Offset
    // CHANNELS maps back onto w_eff_ch itself, so a lone enabled channel
    // keeps being revisited (and counts as a wrap every time).
    always_comb begin
        w_next_ch = w_eff_ch;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_rot_eff[k]) begin
                w_next_ch = SEL_W'((int'(w_eff_ch) + 1 + k) % CHANNELS);
            end
        end
    end

    // Moving to an index not above the current one means the search passed
    // through CHANNELS-1.
    assign w_next_wraps = (w_next_ch <= w_eff_ch);
    assign w_dwell_done = (r_cnt == CNT_LAST);

    // Data selection and manual-select legality. Comparing against each
    // channel index keeps out-of-range selects from indexing past I or M.
    always_comb begin
        w_scan_data = '0;
        w_man_data  = '0;
        w_s_legal   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_eff_ch == SEL_W'(k)) begin
                w_scan_data = I[k*WIDTH +: WIDTH];
            end
            if (S == SEL_W'(k)) begin
                w_man_data = I[k*WIDTH +: WIDTH];
                w_s_legal  = w_mask[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cursor    <= '0;
            r_cnt       <= '0;
            r_wrap_pend <= 1'b0;
            r_y         <= '0;
            r_y_ch      <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
        end else if (!en) begin
            // Frozen: everything holds except the wrap pulse.
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state     <= mode ? ST_SCAN : ST_MANUAL;
                    r_cursor    <= '0;
                    r_cnt       <= '0;
                    r_wrap_pend <= 1'b0;
                end

                ST_MANUAL: begin
                    if (mode) begin
                        // Scan always restarts from channel 0 with a full dwell.
                        r_state     <= ST_SCAN;
                        r_cursor    <= '0;
                        r_cnt       <= '0;
                        r_wrap_pend <= 1'b0;
                    end else if (w_s_legal) begin
                        r_y     <= w_man_data;
                        r_y_ch  <= S;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                    end else begin
                        // Illegal select: keep the last good sample, flag it.
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (!mode) begin
                        r_state <= ST_MANUAL;
                    end else if (!w_eff_found) begin
                        // Nothing eligible to present: hold Y, drop valid.
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end else begin
                        r_y     <= w_scan_data;
                        r_y_ch  <= w_eff_ch;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                        // The pulse belongs to the first sample after a wrap,
                        // not to the last sample of the old frame.
                        r_wrap  <= r_wrap_pend;
                        if (w_dwell_done) begin
                            r_cnt       <= '0;
                            r_cursor    <= w_next_ch;
                            r_wrap_pend <= w_next_wraps;
                        end else begin
                            r_cnt       <= r_cnt + CNT_W'(1);
                            r_cursor    <= w_eff_ch;
                            r_wrap_pend <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Y     = r_y;
    assign Y_ch  = r_y_ch;
    assign valid = r_valid;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule

// File: tb/tb_mux_scan_n.sv
// ----------------------------------------------------------------------------
// tb_mux_scan_n
//
// Two instances of mux_scan_n share clk/rst/en/mode:
//   u_dut0 : WIDTH=4, CHANNELS=4, SEL_W=2, DWELL=3
//   u_dut1 : WIDTH=4, CHANNELS=3, SEL_W=2, DWELL=2 (has an illegal select, 3)
// A reference model describes scan position as an enabled-cycle count since
// entering scan: channel = (t / DWELL) % CHANNELS, wrap when t is a nonzero
// multiple of CHANNELS*DWELL. Directed steps follow the test plan, then a
// randomized phase runs against the same model.
// ----------------------------------------------------------------------------
module tb_mux_scan_n;

    localparam int ST_IDLE = 0;
    localparam int ST_MAN  = 1;
    localparam int ST_SCAN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [1:0]  s0;
    logic [15:0] i0;
    logic [3:0]  y0;
    logic [1:0]  ych0;
    logic        valid0, wrap0, err0;
    logic [1:0]  s1;
    logic [11:0] i1;
    logic [3:0]  y1;
    logic [1:0]  ych1;
    logic        valid1, wrap1, err1;
`ifdef MUX_SCAN_SKIP_MASK_EN
    logic [3:0]  m0 = 4'hF;
    logic [2:0]  m1 = 3'h7;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state, one slot per instance.
    int         m_state [2];
    int         m_t     [2];
    logic [3:0] m_y     [2];
    int         m_ych   [2];
    logic       m_valid [2];
    logic       m_wrap  [2];
    logic       m_err   [2];

    always #5 clk = ~clk;

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .S(s0), .I(i0),
        .Y(y0), .Y_ch(ych0), .valid(valid0), .wrap(wrap0), .err(err0)
`ifdef MUX_SCAN_SKIP_MASK_EN
        , .M(m0)
`endif
    );

    mux_scan_n #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(2)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .S(s1), .I(i1),
        .Y(y1), .Y_ch(ych1), .valid(valid1), .wrap(wrap1), .err(err1)
`ifdef MUX_SCAN_SKIP_MASK_EN
        , .M(m1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One enabled-or-not clock edge of the behavioural model.
    task automatic model_edge(input int n, input int ch, input int dw,
                              input int sel, input logic [15:0] data);
        int c;
        if (rst) begin
            m_state[n] = ST_IDLE;
            m_t[n]     = 0;
            m_y[n]     = '0;
            m_ych[n]   = 0;
            m_valid[n] = 1'b0;
            m_wrap[n]  = 1'b0;
            m_err[n]   = 1'b0;
        end else if (!en) begin
            m_wrap[n] = 1'b0;
        end else begin
            m_wrap[n] = 1'b0;
            case (m_state[n])
                ST_IDLE: begin
                    m_state[n] = mode ? ST_SCAN : ST_MAN;
                    m_t[n]     = 0;
                end
                ST_MAN: begin
                    if (mode) begin
                        m_state[n] = ST_SCAN;
                        m_t[n]     = 0;
                    end else if (sel < ch) begin
                        m_y[n]     = 4'((data >> (4 * sel)) & 16'hF);
                        m_ych[n]   = sel;
                        m_valid[n] = 1'b1;
                        m_err[n]   = 1'b0;
                    end else begin
                        m_valid[n] = 1'b0;
                        m_err[n]   = 1'b1;
                    end
                end
                default: begin
                    if (!mode) begin
                        m_state[n] = ST_MAN;
                    end else begin
                        c          = (m_t[n] / dw) % ch;
                        m_y[n]     = 4'((data >> (4 * c)) & 16'hF);
                        m_ych[n]   = c;
                        m_valid[n] = 1'b1;
                        m_err[n]   = 1'b0;
                        m_wrap[n]  = (m_t[n] > 0) && (m_t[n] % (ch * dw) == 0);
                        m_t[n]++;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("dut0.Y",     32'(y0),     32'(m_y[0]));
        check("dut0.Y_ch",  32'(ych0),   32'(m_ych[0]));
        check("dut0.valid", 32'(valid0), 32'(m_valid[0]));
        check("dut0.wrap",  32'(wrap0),  32'(m_wrap[0]));
        check("dut0.err",   32'(err0),   32'(m_err[0]));
        check("dut1.Y",     32'(y1),     32'(m_y[1]));
        check("dut1.Y_ch",  32'(ych1),   32'(m_ych[1]));
        check("dut1.valid", 32'(valid1), 32'(m_valid[1]));
        check("dut1.wrap",  32'(wrap1),  32'(m_wrap[1]));
        check("dut1.err",   32'(err1),   32'(m_err[1]));
    endtask

    // Inputs are stable across the edge; the model consumes the same values
    // and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge(0, 4, 3, int'(s0), i0);
        model_edge(1, 3, 2, int'(s1), {4'h0, i1});
        #1;
        compare_all();
    endtask

    initial begin : stim
        int exp_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        int guard;

        // Reset held with everything else active.
        rst  = 1'b1;
        en   = 1'b1;
        mode = 1'b1;
        s0   = 2'd1;
        s1   = 2'd1;
        i0   = 16'hDCBA;
        i1   = 12'h987;
        repeat (3) step();
        check("rst.Y",     32'(y0),     32'h0);
        check("rst.Y_ch",  32'(ych0),   32'h0);
        check("rst.valid", 32'(valid0), 32'h0);
        check("rst.wrap",  32'(wrap0),  32'h0);
        check("rst.err",   32'(err0),   32'h0);

        // Manual mode: IDLE edge, then one-cycle registered path.
        rst  = 1'b0;
        mode = 1'b0;
        s0   = 2'd2;
        step();
        check("idle.valid", 32'(valid0), 32'h0);
        step();
        check("man_s2.Y",     32'(y0),     32'hC);
        check("man_s2.Y_ch",  32'(ych0),   32'h2);
        check("man_s2.valid", 32'(valid0), 32'h1);
        check("man_s1.Y_dut1", 32'(y1),    32'h8);
        s0 = 2'd3;
        s1 = 2'd3;
        step();
        check("man_s3.Y",     32'(y0),     32'hD);
        check("oor.Y_hold",   32'(y1),     32'h8);
        check("oor.Y_ch",     32'(ych1),   32'h1);
        check("oor.valid",    32'(valid1), 32'h0);
        check("oor.err",      32'(err1),   32'h1);
        s1 = 2'd0;
        step();
        check("oor_clear.err",   32'(err1),   32'h0);
        check("oor_clear.valid", 32'(valid1), 32'h1);
        check("oor_clear.Y",     32'(y1),     32'h7);

        // Scan: one transition edge, then the full frame plus wrap.
        mode = 1'b1;
        step();
        for (int k = 0; k < 13; k++) begin
            step();
            check("scan.Y_ch", 32'(ych0), 32'(exp_seq[k]));
            check("scan.wrap", 32'(wrap0), 32'(k == 12));
        end

        // Freeze mid-dwell of channel 0: stretched by 5 cycles, no wrap.
        step();
        en = 1'b0;
        repeat (5) begin
            i0 = 16'(($urandom));
            step();
            check("freeze.Y_ch", 32'(ych0), 32'h0);
            check("freeze.wrap", 32'(wrap0), 32'h0);
        end
        en = 1'b1;
        step();
        check("unfreeze.Y_ch", 32'(ych0), 32'h0);
        step();
        check("advance.Y_ch", 32'(ych0), 32'h1);

        // Reset mid-scan at channel 2, then restart with a full dwell on 0.
        guard = 0;
        while (!(m_state[0] == ST_SCAN && m_ych[0] == 2) && guard < 20) begin
            step();
            guard++;
        end
        check("reach_ch2.timeout", 32'(guard < 20), 32'h1);
        rst = 1'b1;
        step();
        check("rst_mid.Y",     32'(y0),     32'h0);
        check("rst_mid.Y_ch",  32'(ych0),   32'h0);
        check("rst_mid.valid", 32'(valid0), 32'h0);
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("restart.Y_ch", 32'(ych0), 32'h0);
        end
        step();
        check("restart_next.Y_ch", 32'(ych0), 32'h1);

        // Randomized phase against the model.
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom_range(0, 5) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            s0   = 2'($urandom);
            s1   = 2'($urandom);
            i0   = 16'($urandom);
            i1   = 12'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
